// File: rtl/clk_gen_pkg.sv
// Shared definitions for the clock divider bank.
// Contents:
//   mode_e       - per-channel output mode (TOGGLE divided clock / PULSE tick)
//   CNT_W_DEF    - default counter / divisor width
//   DEF_DIV_DEF  - default divisor loaded at reset (50 MHz -> 1 kHz in TOGGLE)
//   ch_sel_w()   - width of a channel-select field for a given channel count
package clk_gen_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    localparam int CNT_W_DEF   = 20;
    localparam int DEF_DIV_DEF = 24999;

    // A single-channel bank still gets a 1-bit select so the port never collapses.
    function automatic int ch_sel_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Configuration write bus of the clock divider bank.
// Signals:
//   i_wr_en   - write strobe, one cycle per write
//   i_wr_ch   - target channel index
//   i_wr_div  - divisor value (period of terminal count is value+1 cycles)
//   i_wr_mode - 0 = TOGGLE, 1 = PULSE
// Modports: master drives the bus, slave (the bank) receives it.
interface clk_div_bank_if
    import clk_gen_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = CNT_W_DEF
);
    localparam int WCH_W = ch_sel_w(N_CH);

    logic             i_wr_en;
    logic [WCH_W-1:0] i_wr_ch;
    logic [CNT_W-1:0] i_wr_div;
    logic             i_wr_mode;

    modport master (output i_wr_en, output i_wr_ch, output i_wr_div, output i_wr_mode);
    modport slave  (input  i_wr_en, input  i_wr_ch, input  i_wr_div, input  i_wr_mode);

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active/shadow divisor and mode, registered outputs.
// Ports:
//   i_clk, i_rst   - system clock, asynchronous active-high reset
//   i_en           - run enable; low holds the channel idle and loads shadow values
//   i_sync         - phase-align strobe; restarts the channel and loads shadow values
//   i_wr           - write strobe already decoded for this channel
//   i_wr_div/mode  - values to write into the shadow registers
//   o_clk          - divided clock (TOGGLE) or one-cycle tick (PULSE), 1 cycle after TC
//   o_tc           - one-cycle terminal-count strobe, 1 cycle after TC
module clk_div_ch
    import clk_gen_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wr_div,
    input  mode_e            i_wr_mode,
    output logic             o_clk,
    output logic             o_tc
);
    localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_div_q, act_div_d;
    logic [CNT_W-1:0] sh_div_q, sh_div_d;
    mode_e            act_mode_q, act_mode_d;
    mode_e            sh_mode_q, sh_mode_d;
    logic             phase_q, phase_d;
    logic             clk_q, tc_q;
    logic             tc, wrap, int_bit;

    always_comb begin
        // A write in this cycle is visible to any load happening in the same cycle.
        sh_div_d  = i_wr ? i_wr_div  : sh_div_q;
        sh_mode_d = i_wr ? i_wr_mode : sh_mode_q;

        tc   = i_en && !i_sync && (cnt_q == act_div_q);
        // >= rather than == so a count left above a shrunk divisor still reloads.
        wrap = cnt_q >= act_div_q;

        // Internal bit as seen by the output register in this cycle.
        if (!i_en || i_sync) begin
            int_bit = 1'b0;
        end else if (act_mode_q == MODE_PULSE) begin
            int_bit = tc;
        end else begin
            int_bit = phase_q ^ tc;
        end

        cnt_d      = cnt_q + 1'b1;
        act_div_d  = act_div_q;
        act_mode_d = act_mode_q;
        phase_d    = int_bit;

        if (i_sync || !i_en) begin
            cnt_d      = '0;
            act_div_d  = sh_div_d;
            act_mode_d = sh_mode_d;
        end else if (wrap) begin
            cnt_d      = '0;
            act_div_d  = sh_div_d;
            act_mode_d = sh_mode_d;
            // A mode switch starts the new mode from a low phase.
            if (sh_mode_d != act_mode_q) begin
                phase_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q      <= '0;
            act_div_q  <= DEF_DIV_V;
            sh_div_q   <= DEF_DIV_V;
            act_mode_q <= MODE_TOGGLE;
            sh_mode_q  <= MODE_TOGGLE;
            phase_q    <= 1'b0;
            clk_q      <= 1'b0;
            tc_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            act_div_q  <= act_div_d;
            sh_div_q   <= sh_div_d;
            act_mode_q <= act_mode_d;
            sh_mode_q  <= sh_mode_d;
            phase_q    <= phase_d;
            clk_q      <= int_bit;
            tc_q       <= tc;
        end
    end

    assign o_clk = clk_q;
    assign o_tc  = tc_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH independent programmable clock dividers on the 50 MHz clock.
// Ports:
//   i_clk_50M - system clock (only clock)
//   i_rst     - asynchronous active-high reset
//   i_en      - per-channel run enable
//   i_sync    - one-cycle strobe that restarts all channels in phase
//   cfg       - configuration write bus (clk_div_bank_if.slave)
//   o_clk     - per-channel divided clock / tick strobe
//   o_tc      - per-channel terminal-count strobe
module clk_div_bank
    import clk_gen_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic            i_clk_50M,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_en,
    input  logic            i_sync,
    clk_div_bank_if.slave   cfg,
    output logic [N_CH-1:0] o_clk,
    output logic [N_CH-1:0] o_tc
);
    localparam int WCH_W = ch_sel_w(N_CH);

    logic [N_CH-1:0] wr_sel;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        // Exact index match: a select value >= N_CH matches no channel and is dropped.
        assign wr_sel[g] = cfg.i_wr_en && (cfg.i_wr_ch == WCH_W'(g));

        clk_div_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .i_clk     (i_clk_50M),
            .i_rst     (i_rst),
            .i_en      (i_en[g]),
            .i_sync    (i_sync),
            .i_wr      (wr_sel[g]),
            .i_wr_div  (cfg.i_wr_div),
            .i_wr_mode (mode_e'(cfg.i_wr_mode)),
            .o_clk     (o_clk[g]),
            .o_tc      (o_tc[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Testbench for clk_div_bank: directed scenarios plus randomized traffic, every
// cycle compared against a period/phase reference model of the channel rules.
module tb_clk_div_bank;
    localparam int N   = 4;
    localparam int CW  = 20;
    localparam int DEF = 24999;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] en;
    logic         sync;
    logic [N-1:0] o_clk, o_tc;

    clk_div_bank_if #(.N_CH(N), .CNT_W(CW)) cfg_if ();

    clk_div_bank #(.N_CH(N), .CNT_W(CW), .DEF_DIV(DEF)) dut (
        .i_clk_50M (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_sync    (sync),
        .cfg       (cfg_if),
        .o_clk     (o_clk),
        .o_tc      (o_tc)
    );

    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Reference model: position within the current period, divisor and mode in
    // force, pending values, and the TOGGLE output level.
    int           m_pos [N];
    int           m_div [N];
    int           m_sdiv[N];
    bit           m_mode [N];
    bit           m_smode[N];
    bit           m_lvl [N];
    logic [N-1:0] m_oclk, m_otc;

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_pos[c] = 0; m_div[c] = DEF; m_sdiv[c] = DEF;
            m_mode[c] = 1'b0; m_smode[c] = 1'b0; m_lvl[c] = 1'b0;
        end
        m_oclk = '0; m_otc = '0;
    endtask

    task automatic model_step();
        bit at_end;
        for (int c = 0; c < N; c++) begin
            if (cfg_if.i_wr_en && int'(cfg_if.i_wr_ch) == c) begin
                m_sdiv[c]  = int'(cfg_if.i_wr_div);
                m_smode[c] = cfg_if.i_wr_mode;
            end
            if (sync || !en[c]) begin
                m_oclk[c] = 1'b0; m_otc[c] = 1'b0;
                m_pos[c] = 0; m_lvl[c] = 1'b0;
                m_div[c] = m_sdiv[c]; m_mode[c] = m_smode[c];
            end else begin
                at_end = (m_pos[c] == m_div[c]);
                m_otc[c] = at_end;
                if (m_mode[c]) m_oclk[c] = at_end;
                else begin
                    if (at_end) m_lvl[c] = !m_lvl[c];
                    m_oclk[c] = m_lvl[c];
                end
                if (at_end) begin
                    m_pos[c] = 0;
                    if (m_smode[c] != m_mode[c]) m_lvl[c] = 1'b0;
                    m_mode[c] = m_smode[c];
                    m_div[c]  = m_sdiv[c];
                end else begin
                    m_pos[c] = m_pos[c] + 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check("o_clk", 32'(o_clk), 32'(m_oclk));
        check("o_tc",  32'(o_tc),  32'(m_otc));
    endtask

    task automatic set_wr(input int ch, input int dv, input bit md);
        cfg_if.i_wr_en   = 1'b1;
        cfg_if.i_wr_ch   = 2'(ch);
        cfg_if.i_wr_div  = CW'(dv);
        cfg_if.i_wr_mode = md;
    endtask

    task automatic clr_wr();
        cfg_if.i_wr_en = 1'b0;
    endtask

    initial begin
        int tq[$];
        logic prev;
        int ones, tc1, tc2, rise0, fall0, first;

        rst = 1'b1; en = '0; sync = 1'b0;
        cfg_if.i_wr_en = 1'b0; cfg_if.i_wr_ch = '0; cfg_if.i_wr_div = '0; cfg_if.i_wr_mode = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_clk", 32'(o_clk), 32'd0);
        check("rst_tc",  32'(o_tc),  32'd0);
        rst = 1'b0;
        en  = '1;

        // ch1 to 20 ms period, then phase-align everything.
        set_wr(1, 499999, 1'b0); tick(); clr_wr();
        sync = 1'b1; tick(); sync = 1'b0;
        check("sync_lo0", 32'(o_clk[0]), 32'd0);
        check("sync_lo1", 32'(o_clk[1]), 32'd0);
        repeat (50) tick();

        // ch2: D = 9 loaded with sync, rewritten to 3 at count 5.
        set_wr(2, 9, 1'b0); sync = 1'b1; tick(); clr_wr(); sync = 1'b0;
        prev = o_clk[2];
        for (int k = 1; k <= 30; k++) begin
            if (k == 6) set_wr(2, 3, 1'b0);
            tick();
            if (k == 6) clr_wr();
            if (o_clk[2] !== prev) tq.push_back(k);
            prev = o_clk[2];
        end
        check("c_ntog", 32'(tq.size() >= 3), 32'd1);
        if (tq.size() >= 3) begin
            check("c_first", 32'(tq[0]), 32'd10);
            check("c_half1", 32'(tq[1] - tq[0]), 32'd4);
            check("c_half2", 32'(tq[2] - tq[1]), 32'd4);
        end

        // ch3 PULSE D = 0, then PULSE D = 4.
        set_wr(3, 0, 1'b1); sync = 1'b1; tick(); clr_wr(); sync = 1'b0;
        ones = 0;
        for (int k = 0; k < 10; k++) begin tick(); if (o_clk[3]) ones++; end
        check("d_const1", 32'(ones), 32'd10);
        set_wr(3, 4, 1'b1); tick(); clr_wr();
        repeat (5) tick();
        ones = 0;
        for (int k = 0; k < 50; k++) begin tick(); if (o_clk[3]) ones++; end
        check("d_pulse5", 32'(ones), 32'd10);

        // Randomized writes, enables and syncs with small divisors.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(63) == 0) en[$urandom_range(N-1)] = ~en[$urandom_range(N-1)];
            sync = ($urandom_range(49) == 0);
            if ($urandom_range(7) == 0) set_wr(int'($urandom_range(N-1)), int'($urandom_range(15)), 1'($urandom_range(1)));
            else clr_wr();
            tick();
        end
        clr_wr(); sync = 1'b0; en = '1;

        // All channels PULSE D = 0 (outputs high), then reset mid-period.
        for (int c = 0; c < N; c++) begin set_wr(c, 0, 1'b1); tick(); end
        clr_wr();
        sync = 1'b1; tick(); sync = 1'b0;
        repeat (2) tick();
        check("g_pre", 32'(o_clk), 32'hF);
        #3 rst = 1'b1;
        model_reset();
        #1;
        check("g_rst_clk", 32'(o_clk), 32'd0);
        check("g_rst_tc",  32'(o_tc),  32'd0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("g_hold", 32'({o_clk, o_tc}), 32'd0);
        #4 rst = 1'b0;

        // Default divisors after reset: 1 kHz on every channel.
        tc1 = -1; tc2 = -1; rise0 = -1; fall0 = -1; prev = 1'b0;
        for (int k = 1; k <= 50001; k++) begin
            tick();
            if (o_tc[0]) begin
                if (tc1 < 0) tc1 = k;
                else if (tc2 < 0) tc2 = k;
            end
            if (o_clk[0] && !prev && rise0 < 0) rise0 = k;
            if (!o_clk[0] && prev && fall0 < 0) fall0 = k;
            prev = o_clk[0];
        end
        check("a_tc1",  32'(tc1),   32'd25000);
        check("a_tc2",  32'(tc2),   32'd50000);
        check("a_rise", 32'(rise0), 32'd25000);
        check("a_high", 32'(fall0 - rise0), 32'd25000);

        // Disable ch0 while high, then re-enable with the default divisor.
        set_wr(0, 20, 1'b0); sync = 1'b1; tick(); clr_wr(); sync = 1'b0;
        repeat (25) tick();
        check("e_hi", 32'(o_clk[0]), 32'd1);
        en[0] = 1'b0; tick();
        check("e_off", 32'(o_clk[0]), 32'd0);
        set_wr(0, DEF, 1'b0); tick(); clr_wr();
        repeat (2) tick();
        en[0] = 1'b1;
        first = -1;
        for (int k = 1; k <= 25010; k++) begin
            tick();
            if (o_tc[0]) begin first = k; break; end
        end
        check("e_tc", 32'(first), 32'd25000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning the number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 20, meaning the width of each channel's counter and divisor.
REQ-003 SHALL have parameter DEF_DIV, default 24999, meaning the reset divisor loaded into every channel.
REQ-004 SHALL have port i_clk_50M, input, 1 bit: the 50 MHz system clock; this is the only clock.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port i_en, input, N_CH bits: per-channel run enable.
REQ-007 SHALL have port i_sync, input, 1 bit: single-cycle strobe that phase-aligns all channels.
REQ-008 SHALL have port i_wr_en, input, 1 bit: configuration write strobe.
REQ-009 SHALL have port i_wr_ch, input, $clog2(N_CH) bits (minimum 1): the channel selected for a configuration write.
REQ-010 SHALL have port i_wr_div, input, CNT_W bits: the divisor value to write.
REQ-011 SHALL have port i_wr_mode, input, 1 bit: the mode to write, 0 = TOGGLE, 1 = PULSE.
REQ-012 SHALL have port o_clk, output, N_CH bits: registered divided clock (TOGGLE) or tick strobe (PULSE) per channel.
REQ-013 SHALL have port o_tc, output, N_CH bits: registered one-cycle terminal-count strobe per channel, valid in both modes.

Function
REQ-014 SHALL give each channel a counter that increments from 0 while enabled and reaches terminal count (TC) when counter == active divisor D.
REQ-015 SHALL, at TC, reload the counter to 0 on the next cycle, so that the TC period is D+1 cycles.
REQ-016 SHALL, in TOGGLE mode, invert the channel's internal clock bit at each TC, giving an o_clk period of 2*(D+1) cycles at 50% duty.
REQ-017 SHALL, in PULSE mode, drive the channel's internal bit high for exactly the TC cycle.
REQ-018 SHALL register o_clk and o_tc one cycle after the internal state, giving a fixed latency of 1 cycle from TC to output.
REQ-019 SHALL hold D = 0 as legal: TC every cycle, so TOGGLE gives 25 MHz and PULSE gives a constant 1.
REQ-020 SHALL store a configuration write into the selected channel's shadow divisor and shadow mode only.
REQ-021 SHALL load the shadow values into the active values at the next TC, so that no runt period or glitch occurs.
REQ-022 SHALL, when the channel is disabled, load the shadow values into the active values immediately instead.
REQ-023 SHALL ignore writes with i_wr_ch >= N_CH.
REQ-024 SHALL, when i_en[ch] = 0, hold the counter at 0, hold the internal bit at 0 (o_clk = 0 one cycle later), and keep o_tc = 0.
REQ-025 SHALL, on re-enable, restart from counter 0 with the first TC D cycles after the enable rises.
REQ-026 SHALL, when i_sync = 1, set every channel's counter to 0 and internal bit to 0, load its shadow values into its active values, and suppress TC in that cycle.
REQ-027 SHALL give i_sync priority over TC and over the count increment.
REQ-028 SHALL, when i_wr_en and i_sync occur in the same cycle, apply the written values as active immediately.
REQ-029 SHALL, when a write and a TC on the same channel occur in the same cycle, make the new values active from that reload.
REQ-030 SHALL apply a mode change only at the reload, with the internal bit cleared to 0 at that point.
REQ-031 SHALL never let the counter exceed D: if D shrinks below the current count via the immediate-load path, the counter SHALL reload to 0 on the next cycle.

Reset
REQ-032 SHALL, while i_rst = 1, asynchronously clear all counters, internal bits, o_clk and o_tc to 0.
REQ-033 SHALL, while i_rst = 1, set active and shadow divisors to DEF_DIV and active and shadow modes to TOGGLE.
REQ-034 SHALL, after reset release with i_en high, produce the first TC at cycle DEF_DIV after release; reset asserted mid-period SHALL discard all state with no partial-period output.

Structure
REQ-035 SHALL place the mode enumeration (TOGGLE/PULSE) and the default CNT_W/DEF_DIV constants in shared package clk_gen_pkg.
REQ-036 SHALL implement one channel as sub-module clk_div_ch, instantiated N_CH times by a generate loop; the top level SHALL contain only write decode and fan-out.

Verification
REQ-037 SHALL cover: reset, all channels enabled, DEF_DIV = 24999 -> o_clk[0] toggles every 25000 cycles, period 1 ms, 50% duty; o_tc pulses every 25000 cycles.
REQ-038 SHALL cover: write ch1 D = 499999 in TOGGLE, then i_sync -> o_clk[1] period 20 ms; o_clk[0] and o_clk[1] both low in the cycle after i_sync and rising edges aligned thereafter.
REQ-039 SHALL cover: ch2 running D = 9, write D = 3 at count 5 -> current period completes at 10 cycles, then 4-cycle half-periods with no glitch.
REQ-040 SHALL cover: ch3 PULSE D = 0 -> o_clk[3] constant 1; PULSE D = 4 -> one-cycle high every 5 cycles.
REQ-041 SHALL cover: deassert i_en[0] mid-period -> o_clk[0] = 0 next cycle; reassert -> first o_tc[0] after 25000 cycles.
REQ-042 SHALL cover: i_rst pulse mid-period with modified divisors -> all outputs 0 immediately, divisors back to 24999.
